button_ctrl: RTL and testbench
==============================

# button_ctrl

Button event controller for the desk clock's user inputs. It generates the shared sample strobe that paces the per-button debouncers, then consumes their debounced states. It arbitrates between simultaneous presses and sequences press, hold and auto-repeat timing, emitting single-cycle increment/mode events to the clock core.

## Interface

Parameters:
- SAMPLE_DIV, default 2048: enabled i_clk cycles per sample tick; must be ≥ 2.
- HOLD_TICKS, default 50: sample ticks from the initial press event to the first auto-repeat event; must be ≥ 2.
- REPEAT_TICKS, default 10: sample ticks between successive auto-repeat events; must be ≥ 2.

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset; one clock.
- i_en  input  1  global enable; low freezes divider and FSM.
- i_btn_set  input  1  debounced set/mode button state, 1 = pressed.
- i_btn_hr  input  1  debounced hours button state.
- i_btn_min  input  1  debounced minutes button state.
- o_sample_stb  output  1  one-cycle sample tick, fed to all debouncers.
- o_set_stb  output  1  one-cycle mode-toggle event.
- o_hr_stb  output  1  one-cycle hours-increment event.
- o_min_stb  output  1  one-cycle minutes-increment event.
- o_repeating  output  1  level; high while in REPEAT.

## Operation

- Divider: counter 0..SAMPLE_DIV-1, width $clog2(SAMPLE_DIV).
  - Increments only when i_en=1; wraps to 0.
  - o_sample_stb is registered and high for exactly one cycle each time the counter wraps.
- Tick: every FSM decision is made in a cycle where o_sample_stb=1 and i_en=1. Button inputs are sampled only in that cycle; between ticks they are ignored.
- Priority when more than one button is pressed: set > hr > min. The winner becomes the owner; all others are ignored.
- FSM states: IDLE, HOLD, REPEAT, LOCKOUT.
  - IDLE, tick with any button pressed:
    - Latch owner; fire owner's event.
    - Owner = set: go to LOCKOUT (no repeat on set).
    - Otherwise: go to HOLD with hold_cnt=0.
  - HOLD, tick:
    - Owner released: go to LOCKOUT, no event.
    - Else if hold_cnt==HOLD_TICKS-1: fire event, go to REPEAT with rep_cnt=0.
    - Else: hold_cnt++.
  - REPEAT, tick:
    - Owner released: go to LOCKOUT.
    - Else if rep_cnt==REPEAT_TICKS-1: fire event, rep_cnt=0.
    - Else: rep_cnt++.
  - LOCKOUT, tick:
    - All three buttons released: go to IDLE.
    - Otherwise stay. Presses of other buttons are ignored until a full release.
- Release check takes precedence over any pending event on the same tick.
- Counter widths: $clog2(HOLD_TICKS) and $clog2(REPEAT_TICKS); counters never exceed their terminal value.
- i_en=0: divider, FSM and counters hold. No o_sample_stb and no events while low; an event already registered still completes its single cycle.
- Reset (asynchronous, any time, including mid-REPEAT): state=IDLE, divider=0, counters=0, owner cleared.

## Timing

- Reset values: o_sample_stb=0, o_set_stb=0, o_hr_stb=0, o_min_stb=0, o_repeating=0.
- First o_sample_stb: SAMPLE_DIV enabled cycles after reset deassertion; then period SAMPLE_DIV while i_en=1.
- Event latency: o_*_stb is asserted on the cycle immediately after the tick cycle that fires it. Width is exactly one i_clk cycle; at most one event output is high in any cycle.
- Press-to-first-repeat: HOLD_TICKS ticks. Repeat period: REPEAT_TICKS ticks.
- o_repeating: rises with the first repeat event; falls the cycle after the tick that leaves REPEAT.
- Release to re-arm: the next tick with all buttons released returns to IDLE. A press becomes eligible on the tick after that.

## Test plan

Bench parameters: SAMPLE_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.

1. Divider: hold i_en=1, no buttons.
   - Required: o_sample_stb pulses at enabled cycles 4, 8, 12, always one cycle wide.
   - Drop i_en for 5 cycles, then restore: the gap extends the period by exactly 5 cycles.
2. Short press: i_btn_hr high for 1 tick.
   - Required: exactly one o_hr_stb, one cycle after that tick; no repeat; back in IDLE two ticks after release.
3. Auto-repeat: i_btn_min held for ticks T0..T7.
   - Required: o_min_stb after T0, T3, T5, T7 (4 pulses).
   - o_repeating high from after T3 until after T8.
4. Arbitration: i_btn_set and i_btn_hr rise on the same tick; release set at T2; hold hr until T6.
   - Required: one o_set_stb, zero o_hr_stb.
   - A fresh hr press after full release yields one o_hr_stb.
5. Freeze and reset:
   - i_en=0 for 20 cycles mid-HOLD: no events, and the repeat timing resumes unchanged once i_en returns.
   - i_reset pulse mid-REPEAT: all outputs 0 immediately; a held button produces a fresh press event on the first tick after reset.

Source files
------------

// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_ctrl
//  Purpose  : Button event controller for the desk clock user inputs.
//             Generates the shared sample strobe that paces the button
//             debouncers, then consumes their debounced states: arbitrates
//             simultaneous presses (set > hr > min), and sequences press,
//             hold and auto-repeat timing into single-cycle events.
//
//  Ports    : i_clk         system clock, rising edge
//             i_reset       asynchronous active-high reset
//             i_en          global enable, low freezes divider and FSM
//             i_btn_set     debounced set/mode button (1 = pressed)
//             i_btn_hr      debounced hours button
//             i_btn_min     debounced minutes button
//             o_sample_stb  one-cycle sample tick for the debouncers
//             o_set_stb     one-cycle mode-toggle event
//             o_hr_stb      one-cycle hours-increment event
//             o_min_stb     one-cycle minutes-increment event
//             o_repeating   level, high while auto-repeating
//
//  Revision : 1.0  initial release
// ============================================================================
module button_ctrl #(
    parameter int SAMPLE_DIV   = 2048,  // enabled clocks per sample tick, >= 2
    parameter int HOLD_TICKS   = 50,    // ticks from press to first repeat, >= 2
    parameter int REPEAT_TICKS = 10     // ticks between repeats, >= 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_btn_set,
    input  logic i_btn_hr,
    input  logic i_btn_min,
    output logic o_sample_stb,
    output logic o_set_stb,
    output logic o_hr_stb,
    output logic o_min_stb,
    output logic o_repeating
);

    localparam int c_div_w  = $clog2(SAMPLE_DIV);
    localparam int c_hold_w = $clog2(HOLD_TICKS);
    localparam int c_rep_w  = $clog2(REPEAT_TICKS);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);
    localparam logic [c_rep_w-1:0]  c_rep_last  = c_rep_w'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Sample divider
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_sample_pend;
    logic               w_tick;

    // r_sample_pend is the registered wrap flag. It is frozen together with
    // the counter while i_en is low, so a tick that lands in a freeze is
    // deferred rather than lost, and the period stretches by exactly the
    // length of the gap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt     <= '0;
            r_sample_pend <= 1'b0;
        end else if (i_en) begin
            if (r_div_cnt == c_div_last) begin
                r_div_cnt     <= '0;
                r_sample_pend <= 1'b1;
            end else begin
                r_div_cnt     <= r_div_cnt + c_div_w'(1);
                r_sample_pend <= 1'b0;
            end
        end
    end

    // Gating with i_en keeps the strobe (and every FSM decision) silent
    // while frozen.
    assign w_tick       = r_sample_pend & i_en;
    assign o_sample_stb = w_tick;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Button vectors are one-hot ordered {min, hr, set}.
    logic [2:0] w_btn;
    logic [2:0] w_win;
    logic       w_any;

    assign w_btn = {i_btn_min, i_btn_hr, i_btn_set};
    assign w_any = |w_btn;

    always_comb begin
        w_win = 3'b000;
        if (i_btn_set) begin
            w_win = 3'b001;
        end else if (i_btn_hr) begin
            w_win = 3'b010;
        end else if (i_btn_min) begin
            w_win = 3'b100;
        end
    end

    // ------------------------------------------------------------------
    // Press / hold / repeat sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_owner;
    logic [2:0]          w_owner_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [c_rep_w-1:0]  r_rep_cnt;
    logic [c_rep_w-1:0]  w_rep_nxt;
    logic [2:0]          w_fire;
    logic [2:0]          r_evt;
    logic                w_owner_held;

    assign w_owner_held = |(r_owner & w_btn);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 3'b000;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_evt      <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            // Loaded every cycle so a fired event always drops after one
            // clock, even if i_en falls right behind it.
            r_evt      <= w_fire;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_fire      = 3'b000;

        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_owner_nxt = w_win;
                        w_fire      = w_win;
                        // The set button toggles mode once; it never repeats.
                        if (w_win[0]) begin
                            w_state_nxt = ST_LOCKOUT;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_hold_nxt  = '0;
                        end
                    end
                end

                ST_HOLD: begin
                    // Release wins over a pending repeat on the same tick.
                    if (!w_owner_held) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else if (r_hold_cnt == c_hold_last) begin
                        w_fire      = r_owner;
                        w_state_nxt = ST_REPEAT;
                        w_rep_nxt   = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_hold_w'(1);
                    end
                end

                ST_REPEAT: begin
                    if (!w_owner_held) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else if (r_rep_cnt == c_rep_last) begin
                        w_fire    = r_owner;
                        w_rep_nxt = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + c_rep_w'(1);
                    end
                end

                ST_LOCKOUT: begin
                    // Only a full release of all three buttons re-arms.
                    if (!w_any) begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = 3'b000;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = 3'b000;
                end
            endcase
        end
    end

    assign o_set_stb   = r_evt[0];
    assign o_hr_stb    = r_evt[1];
    assign o_min_stb   = r_evt[2];
    assign o_repeating = (r_state == ST_REPEAT);

endmodule
`default_nettype wire

// File: tb/tb_button_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_ctrl
//  Purpose  : Self-checking bench for button_ctrl. A behavioural model
//             tracks how many ticks the owning button has been held and
//             derives events arithmetically from the press/hold/repeat
//             rules; directed scenarios are followed by random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_ctrl;

    localparam int SAMPLE_DIV   = 4;
    localparam int HOLD_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic btn_set = 1'b0;
    logic btn_hr  = 1'b0;
    logic btn_min = 1'b0;
    logic sample_stb, set_stb, hr_stb, min_stb, repeating;

    button_ctrl #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_btn_set   (btn_set),
        .i_btn_hr    (btn_hr),
        .i_btn_min   (btn_min),
        .o_sample_stb(sample_stb),
        .o_set_stb   (set_stb),
        .o_hr_stb    (hr_stb),
        .o_min_stb   (min_stb),
        .o_repeating (repeating)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: phase 0 = free, 1 = owned, 2 = locked out.
    int m_cnt;      // enabled cycles since reset
    bit m_pend;     // divider has wrapped, tick due
    bit m_tick;     // a tick happened on the last edge
    int phase;
    int owner;      // 0 set, 1 hr, 2 min
    int held;       // ticks since the press tick
    bit e_set, e_hr, e_min;

    int cyc;
    int act_set, act_hr, act_min;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_tick = 0;
        phase = 0; owner = 0; held = 0;
        e_set = 0; e_hr = 0; e_min = 0;
    endtask

    task automatic fire(input int who);
        case (who)
            0: e_set = 1;
            1: e_hr  = 1;
            default: e_min = 1;
        endcase
    endtask

    task automatic model_edge();
        bit [2:0] b;
        b = {btn_min, btn_hr, btn_set};
        m_tick = m_pend && en;
        e_set = 0; e_hr = 0; e_min = 0;
        if (en) begin
            m_cnt++;
            m_pend = (m_cnt % SAMPLE_DIV) == 0;
        end
        if (m_tick) begin
            case (phase)
                0: if (b != 0) begin
                    owner = b[0] ? 0 : (b[1] ? 1 : 2);
                    fire(owner);
                    held  = 0;
                    phase = (owner == 0) ? 2 : 1;
                end
                1: if (!b[owner]) begin
                    phase = 2;
                end else begin
                    held++;
                    if (held == HOLD_TICKS ||
                        (held > HOLD_TICKS && (held - HOLD_TICKS) % REPEAT_TICKS == 0))
                        fire(owner);
                end
                default: if (b == 0) phase = 0;
            endcase
        end
    endtask

    // One clock: model advances at the edge, outputs compared at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("sample_stb", sample_stb, m_pend && en);
        check("set_stb", set_stb, e_set);
        check("hr_stb", hr_stb, e_hr);
        check("min_stb", min_stb, e_min);
        check("repeating", repeating, (phase == 1) && (held >= HOLD_TICKS));
        act_set += int'(set_stb);
        act_hr  += int'(hr_stb);
        act_min += int'(min_stb);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = n * SAMPLE_DIV * 4 + 50;
        while (seen < n && budget > 0) begin
            cycle();
            if (m_tick) seen++;
            budget--;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic clr_counts();
        act_set = 0; act_hr = 0; act_min = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_sample_stb", sample_stb, 0);
        check("rst_set_stb", set_stb, 0);
        check("rst_hr_stb", hr_stb, 0);
        check("rst_min_stb", min_stb, 0);
        check("rst_repeating", repeating, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic set_btns(input logic [2:0] b);
        {btn_min, btn_hr, btn_set} = b;
    endtask

    initial begin
        int first;
        int nstb;
        int guard;
        int ev_freeze;

        model_reset();
        clr_counts();
        cyc = 0;

        // Reset values
        @(negedge clk);
        do_reset();

        // 1. Divider period and freeze gap
        first = -1; nstb = 0;
        repeat (12) begin
            cycle();
            if (sample_stb) begin
                nstb++;
                if (first < 0) first = cyc;
            end
        end
        check("first_stb_cycle", first, 4);
        check("stb_count_12", nstb, 3);
        repeat (2) cycle();
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!sample_stb && guard < 20);
        check("div_gap_period", cyc - 12, 9);

        // 2. Short press
        clr_counts();
        set_btns(3'b010);
        wait_ticks(1);
        set_btns(3'b000);
        wait_ticks(2);
        check("short_hr_count", act_hr, 1);
        set_btns(3'b100);
        wait_ticks(1);
        set_btns(3'b000);
        check("rearm_min_count", act_min, 1);
        wait_ticks(2);

        // 3. Auto-repeat: min held T0..T7
        clr_counts();
        set_btns(3'b100);
        wait_ticks(4);
        check("rep_after_T3", repeating, 1);
        wait_ticks(4);
        set_btns(3'b000);
        check("rep_after_T7", repeating, 1);
        wait_ticks(1);
        check("rep_after_T8", repeating, 0);
        check("repeat_min_count", act_min, 4);
        wait_ticks(1);

        // 4. Arbitration set vs hr
        clr_counts();
        set_btns(3'b011);
        wait_ticks(2);
        set_btns(3'b010);
        wait_ticks(5);
        set_btns(3'b000);
        wait_ticks(2);
        check("arb_set_count", act_set, 1);
        check("arb_hr_count", act_hr, 0);
        set_btns(3'b010);
        wait_ticks(1);
        set_btns(3'b000);
        wait_ticks(2);
        check("fresh_hr_count", act_hr, 1);

        // 5a. Freeze mid-HOLD
        clr_counts();
        set_btns(3'b010);
        wait_ticks(2);
        en = 1'b0;
        ev_freeze = act_hr;
        repeat (20) cycle();
        check("freeze_no_events", act_hr - ev_freeze, 0);
        en = 1'b1;
        wait_ticks(6);
        set_btns(3'b000);
        wait_ticks(2);
        check("freeze_hr_count", act_hr, 4);

        // 5b. Reset mid-REPEAT with the button still held
        set_btns(3'b100);
        wait_ticks(5);
        check("rep_before_rst", repeating, 1);
        do_reset();
        clr_counts();
        wait_ticks(1);
        check("post_rst_min", act_min, 1);
        set_btns(3'b000);
        wait_ticks(2);

        // Random stimulus
        for (int i = 0; i < 40; i++) begin
            logic [2:0] b;
            b = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            set_btns(b);
            wait_ticks($urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 6)) cycle();
                en = 1'b1;
            end
            repeat ($urandom_range(0, 3)) cycle();
            if ($urandom_range(0, 11) == 0) do_reset();
        end
        set_btns(3'b000);
        wait_ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
